regfile_banked: RTL and testbench
=================================

Name: regfile_banked

Overview:
- Parametrised successor to the 8x8 CPU register file: configurable width, depth and bank count.
- Adds optional write-to-read bypass, an optional hardwired-zero register 0, and a sequential bank-to-bank copy engine for context save/restore.
- Sits in the CPU datapath between decode (register addresses) and ALU/writeback.
- Keeps the debug read port, now bank-addressable.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 8, registers per bank; power of two, >=2. ADDR_W = clog2(DEPTH).
- NBANKS, 2, number of register banks; power of two, >=2. BANK_W = clog2(NBANKS).
- BYPASS, 1, 1 = same-cycle write data forwarded to the read ports.
- ZERO_R0, 0, 1 = register 0 of every bank reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bank_sel  in  BANK_W  active bank for port reads and writes.
- we  in  1  write enable.
- rd_in  in  ADDR_W  write address.
- data  in  WIDTH  write data.
- rs1_in  in  ADDR_W  read address 1.
- rs2_in  in  ADDR_W  read address 2.
- rs1_out  out  WIDTH  read data 1 (combinational).
- rs2_out  out  WIDTH  read data 2 (combinational).
- copy_start  in  1  single-cycle request to start a bank copy.
- copy_src  in  BANK_W  source bank.
- copy_dst  in  BANK_W  destination bank.
- copy_busy  out  1  copy in progress.
- copy_done  out  1  one-cycle completion pulse.
- debug_bank  in  BANK_W  debug bank select.
- debug_reg_select  in  ADDR_W  debug register select.
- debug_reg_value  out  WIDTH  debug read data (combinational, no bypass).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All NBANKS*DEPTH registers = 0.
  - Copy FSM = IDLE, index = 0, copy_busy = 0, copy_done = 0.
  - Read outputs therefore 0.
  - Reset mid-copy aborts the copy; no done pulse.
- Port write: at a rising edge with we=1, registers[bank_sel][rd_in] <= data. Ignored when ZERO_R0=1 and rd_in=0.
- Port reads:
  - rsN_out = registers[bank_sel][rsN_in], combinational.
  - ZERO_R0=1 and rsN_in=0 -> 0.
  - BYPASS=1 and we=1 and rd_in==rsN_in (and not the zero reg) -> rsN_out = data in the same cycle.
  - BYPASS=0 -> the old value is visible until after the edge.
- Copy FSM states: IDLE, COPY, DONE.
  - IDLE: on copy_start=1, latch src/dst.
    - src!=dst -> COPY with idx=0.
    - src==dst -> DONE directly; no registers modified.
  - COPY:
    - Each cycle, registers[dst][idx] <= registers[src][idx], using the pre-edge value.
    - idx increments; at idx==DEPTH-1 the copy is performed and the FSM goes to DONE.
    - Occupancy: exactly DEPTH cycles. copy_busy=1 in COPY only.
  - DONE: copy_done=1 for exactly one cycle, then IDLE.
  - Latency: start sampled at edge T -> copy_busy high T+1..T+DEPTH -> copy_done high cycle T+DEPTH+1.
- copy_start while not IDLE: ignored. copy_src/copy_dst are sampled only at the accepting edge.
- Port/copy conflict:
  - A port write to the same entry the copy writes in that cycle wins; the copy value for that entry is dropped.
  - Port writes to other entries, including the src bank, proceed normally.
  - A src entry written before the copy index reaches it is copied with its new value.
- ZERO_R0=1: copies of index 0 leave register 0 at zero.
- bank_sel may change any cycle; reads follow it combinationally. The copy engine is independent of bank_sel.
- Debug port:
  - debug_reg_value = registers[debug_bank][debug_reg_select], combinational.
  - Reflects stored state only: no bypass.
  - ZERO_R0 applies.

Test Plan:
- Reset and readback: assert rst_n=0 mid-simulation after writing values -> all rsN_out and debug reads return 0 in every bank; copy_busy=0.
- Write/read with bypass: bank 0, we=1, rd_in=3, data=8'hA5, rs1_in=3 in the same cycle.
  - BYPASS=1: rs1_out=A5 before the edge.
  - BYPASS=0: rs1_out=00 before the edge, A5 after.
- Bank isolation: write 8'h11 to bank0 r2 and 8'h22 to bank1 r2 -> toggling bank_sel shows 11/22; debug_bank reads match.
- Copy: fill bank0 r0..r7 with 8'h10..8'h17, pulse copy_start src=0 dst=1 at edge T.
  - copy_busy high for 8 cycles, copy_done high at T+9 only.
  - Bank1 then reads 10..17; a second copy_start during busy is ignored.
- Conflict: during the copy, port write bank1 r5=8'hEE on the cycle idx=5 -> bank1 r5=EE after done. Write bank0 r7=8'h77 before idx 7 -> bank1 r7=77.
- Reset mid-copy and ZERO_R0=1:
  - rst_n low at idx=4 -> all zero, no copy_done.
  - ZERO_R0=1: write r0=8'hFF -> reads 00, including after a copy.

Source files
------------

// File: rtl/regfile_banked.sv
// Banked CPU register file with optional write-to-read bypass, optional
// hardwired-zero register 0, and a sequential bank-to-bank copy engine that
// supports context save and restore.
module regfile_banked #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int NBANKS  = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BANK_W = $clog2(NBANKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [WIDTH-1:0]  data,
    input  logic [ADDR_W-1:0] rs1_in,
    input  logic [ADDR_W-1:0] rs2_in,
    output logic [WIDTH-1:0]  rs1_out,
    output logic [WIDTH-1:0]  rs2_out,
    input  logic              copy_start,
    input  logic [BANK_W-1:0] copy_src,
    input  logic [BANK_W-1:0] copy_dst,
    output logic              copy_busy,
    output logic              copy_done,
    input  logic [BANK_W-1:0] debug_bank,
    input  logic [ADDR_W-1:0] debug_reg_select,
    output logic [WIDTH-1:0]  debug_reg_value
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  regs_q [NBANKS][DEPTH];
    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [BANK_W-1:0] src_q;
    logic [BANK_W-1:0] dst_q;
    logic              busy_q;
    logic              done_q;

    logic              port_we;
    logic              copy_we;

    // Register 0 is read-only when it is hardwired to zero.
    assign port_we = we && !(ZERO_R0 && (rd_in == '0));
    assign copy_we = (state_q == S_COPY) && !(ZERO_R0 && (idx_q == '0));

    // Copy engine: latch the request, walk every index once, then pulse done.
    // NOTE: state is updated with non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (copy_start) begin
                        src_q <= copy_src;
                        dst_q <= copy_dst;
                        idx_q <= '0;
                        if (copy_src != copy_dst) begin
                            state_q <= S_COPY;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_COPY: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: copy write first, port write last so a port write to the same
    // entry overrides the copied value.
    // NOTE: the array is reset because the architectural state must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANKS; b++) begin
                for (int r = 0; r < DEPTH; r++) begin
                    regs_q[b][r] <= '0;
                end
            end
        end else begin
            if (copy_we) begin
                regs_q[dst_q][idx_q] <= regs_q[src_q][idx_q];
            end
            if (port_we) begin
                regs_q[bank_sel][rd_in] <= data;
            end
        end
    end

    // Read ports: zero register, then same-cycle bypass, then stored value.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        rs1_out = regs_q[bank_sel][rs1_in];
        rs2_out = regs_q[bank_sel][rs2_in];
        if (BYPASS && we && (rd_in == rs1_in)) begin
            rs1_out = data;
        end
        if (BYPASS && we && (rd_in == rs2_in)) begin
            rs2_out = data;
        end
        if (ZERO_R0 && (rs1_in == '0)) begin
            rs1_out = '0;
        end
        if (ZERO_R0 && (rs2_in == '0)) begin
            rs2_out = '0;
        end
    end

    // Debug port shows stored state only, never the bypass path.
    always_comb begin
        debug_reg_value = regs_q[debug_bank][debug_reg_select];
        if (ZERO_R0 && (debug_reg_select == '0)) begin
            debug_reg_value = '0;
        end
    end

    assign copy_busy = busy_q;
    assign copy_done = done_q;

endmodule

// File: tb/tb_regfile_banked.sv
// Directed bench for regfile_banked: three instances share stimulus
// (default, no bypass, hardwired zero) and are compared to hand values.
module tb_regfile_banked;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bank_sel;
    logic       we;
    logic [2:0] rd_in;
    logic [7:0] data;
    logic [2:0] rs1_in;
    logic [2:0] rs2_in;
    logic       copy_start;
    logic       copy_src;
    logic       copy_dst;
    logic       debug_bank;
    logic [2:0] debug_reg_select;

    logic [7:0] rs1_a, rs2_a, dbg_a;
    logic [7:0] rs1_b, rs2_b, dbg_b;
    logic [7:0] rs1_z, rs2_z, dbg_z;
    logic       busy_a, done_a, busy_b, done_b, busy_z, done_z;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    regfile_banked u_dut (
        .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel), .we(we), .rd_in(rd_in),
        .data(data), .rs1_in(rs1_in), .rs2_in(rs2_in), .rs1_out(rs1_a),
        .rs2_out(rs2_a), .copy_start(copy_start), .copy_src(copy_src),
        .copy_dst(copy_dst), .copy_busy(busy_a), .copy_done(done_a),
        .debug_bank(debug_bank), .debug_reg_select(debug_reg_select),
        .debug_reg_value(dbg_a)
    );

    regfile_banked #(.BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel), .we(we), .rd_in(rd_in),
        .data(data), .rs1_in(rs1_in), .rs2_in(rs2_in), .rs1_out(rs1_b),
        .rs2_out(rs2_b), .copy_start(copy_start), .copy_src(copy_src),
        .copy_dst(copy_dst), .copy_busy(busy_b), .copy_done(done_b),
        .debug_bank(debug_bank), .debug_reg_select(debug_reg_select),
        .debug_reg_value(dbg_b)
    );

    regfile_banked #(.ZERO_R0(1'b1)) u_zero (
        .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel), .we(we), .rd_in(rd_in),
        .data(data), .rs1_in(rs1_in), .rs2_in(rs2_in), .rs1_out(rs1_z),
        .rs2_out(rs2_z), .copy_start(copy_start), .copy_src(copy_src),
        .copy_dst(copy_dst), .copy_busy(busy_z), .copy_done(done_z),
        .debug_bank(debug_bank), .debug_reg_select(debug_reg_select),
        .debug_reg_value(dbg_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Select a debug location mid-cycle, clear of the rising edge.
    task automatic peek(input logic b, input logic [2:0] r);
        @(negedge clk);
        debug_bank       = b;
        debug_reg_select = r;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       seen;
        logic [7:0] exp_v;

        rst_n = 1'b1; bank_sel = 1'b0; we = 1'b0; rd_in = '0; data = '0;
        rs1_in = '0; rs2_in = '0; copy_start = 1'b0; copy_src = 1'b0;
        copy_dst = 1'b0; debug_bank = 1'b0; debug_reg_select = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_rs1", rs1_a, 8'h00);
        check("reset_dbg", dbg_a, 8'h00);
        check("reset_busy", busy_a, 1'b0);
        check("reset_done", done_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Same-cycle write/read of bank0 r3.
        bank_sel = 1'b0; we = 1'b1; rd_in = 3'd3; data = 8'hA5;
        rs1_in = 3'd3; rs2_in = 3'd4;
        #1;
        check("bypass_rs1", rs1_a, 8'hA5);
        check("nobypass_rs1_before", rs1_b, 8'h00);
        check("bypass_rs2_other", rs2_a, 8'h00);
        check("nobypass_rs2_other", rs2_b, 8'h00);
        check("zero_bypass_rs1", rs1_z, 8'hA5);
        step();
        we = 1'b0;
        #1;
        check("nobypass_rs1_after", rs1_b, 8'hA5);
        check("bypass_rs1_after", rs1_a, 8'hA5);

        // Bank isolation on r2.
        we = 1'b1; rd_in = 3'd2; bank_sel = 1'b0; data = 8'h11;
        step();
        bank_sel = 1'b1; data = 8'h22;
        step();
        we = 1'b0; rs1_in = 3'd2; bank_sel = 1'b0;
        #1 check("iso_bank0", rs1_a, 8'h11);
        bank_sel = 1'b1;
        #1 check("iso_bank1", rs1_a, 8'h22);
        debug_bank = 1'b0; debug_reg_select = 3'd2;
        #1 check("iso_dbg0", dbg_a, 8'h11);
        debug_bank = 1'b1;
        #1 check("iso_dbg1", dbg_a, 8'h22);
        we = 1'b1; rd_in = 3'd2; data = 8'h55;
        #1;
        check("dbg_no_bypass", dbg_a, 8'h22);
        check("rs1_bypass_bank1", rs1_a, 8'h55);
        we = 1'b0;

        // Fill bank0 with 10..17.
        step();
        bank_sel = 1'b0; we = 1'b1;
        for (int r = 0; r < 8; r++) begin
            rd_in = 3'(r);
            data  = 8'h10 + 8'(r);
            step();
        end
        we = 1'b0;

        // Copy bank0 -> bank1 with conflicts and an ignored second start.
        copy_src = 1'b0; copy_dst = 1'b1; copy_start = 1'b1;
        step();
        copy_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("copy_busy_%0d", i), busy_a, 1'b1);
            check($sformatf("copy_nodone_%0d", i), done_a, 1'b0);
            we = 1'b0; copy_start = 1'b0;
            if (i == 2) begin
                copy_start = 1'b1; copy_src = 1'b1; copy_dst = 1'b0;
            end
            if (i == 3) begin
                we = 1'b1; bank_sel = 1'b0; rd_in = 3'd7; data = 8'h77;
            end
            if (i == 5) begin
                we = 1'b1; bank_sel = 1'b1; rd_in = 3'd5; data = 8'hEE;
            end
            step();
        end
        we = 1'b0; copy_start = 1'b0;
        check("copy_done_pulse", done_a, 1'b1);
        check("copy_busy_end", busy_a, 1'b0);
        check("copy_done_nobyp", done_b, 1'b1);
        check("copy_busy_nobyp", busy_b, 1'b0);
        check("copy_done_zero", done_z, 1'b1);
        check("copy_busy_zero", busy_z, 1'b0);
        step();
        check("copy_done_cleared", done_a, 1'b0);
        check("copy_idle_busy", busy_a, 1'b0);

        for (int r = 0; r < 8; r++) begin
            peek(1'b1, 3'(r));
            exp_v = (r == 5) ? 8'hEE : (r == 7) ? 8'h77 : 8'h10 + 8'(r);
            check($sformatf("bank1_r%0d", r), dbg_a, exp_v);
        end
        for (int r = 0; r < 8; r++) begin
            peek(1'b0, 3'(r));
            exp_v = (r == 7) ? 8'h77 : 8'h10 + 8'(r);
            check($sformatf("bank0_r%0d", r), dbg_a, exp_v);
        end
        peek(1'b1, 3'd5);
        check("nobyp_bank1_r5", dbg_b, 8'hEE);
        peek(1'b1, 3'd0);
        check("zero_bank1_r0", dbg_z, 8'h00);

        // Copy with src == dst finishes in one cycle.
        step();
        copy_src = 1'b1; copy_dst = 1'b1; copy_start = 1'b1;
        step();
        copy_start = 1'b0;
        check("self_copy_done", done_a, 1'b1);
        check("self_copy_busy", busy_a, 1'b0);
        step();
        check("self_copy_done_clear", done_a, 1'b0);
        peek(1'b1, 3'd5);
        check("self_copy_unchanged", dbg_a, 8'hEE);

        // Reset in the middle of a copy.
        step();
        copy_src = 1'b0; copy_dst = 1'b1; copy_start = 1'b1;
        step();
        copy_start = 1'b0;
        repeat (4) step();
        check("midcopy_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy_a, 1'b0);
        check("midreset_done", done_a, 1'b0);
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
                peek(1'(b), 3'(r));
                check($sformatf("midreset_b%0d_r%0d", b, r), dbg_a, 8'h00);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("no_done_after_abort_%0d", k), done_a, 1'b0);
        end

        // Hardwired zero register.
        bank_sel = 1'b0; we = 1'b1; rd_in = 3'd0; data = 8'hFF;
        rs1_in = 3'd0; rs2_in = 3'd0;
        #1;
        check("zero_r0_bypass", rs1_z, 8'h00);
        check("zero_r0_bypass_rs2", rs2_z, 8'h00);
        check("dflt_r0_bypass", rs1_a, 8'hFF);
        step();
        we = 1'b0;
        #1;
        check("zero_r0_stored", rs1_z, 8'h00);
        check("dflt_r0_stored", rs1_a, 8'hFF);
        copy_src = 1'b0; copy_dst = 1'b1; copy_start = 1'b1;
        step();
        copy_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (done_a) seen = 1'b1;
        end
        check("zero_copy_done_seen", seen, 1'b1);
        peek(1'b1, 3'd0);
        check("zero_copy_r0", dbg_z, 8'h00);
        check("dflt_copy_r0", dbg_a, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
